// File: rtl/pipeline_hazard_unit.sv
// Hazard controller for the 5-stage pipeline: scoreboards in-flight instructions after ID and
// derives forwarding selects, WB->ID bypass, load-use stall and branch/jump flush.
module pipeline_hazard_unit #(
  parameter int unsigned ADDR_W         = 5,
  parameter int unsigned DEPTH          = 3,
  parameter int unsigned REDIRECT_STAGE = 2,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [ADDR_W-1:0]        id_rs,
  input  logic [ADDR_W-1:0]        id_rt,
  input  logic                     id_uses_rs,
  input  logic                     id_uses_rt,
  input  logic [ADDR_W-1:0]        id_dest,
  input  logic                     id_regwrite,
  input  logic                     id_memread,
  input  logic                     redirect,
  input  logic                     redirect_from_id,
  output logic                     stall,
  output logic                     flush_if_id,
  output logic                     ex_bubble,
  output logic [$clog2(DEPTH)-1:0] fwd_a_sel,
  output logic [$clog2(DEPTH)-1:0] fwd_b_sel,
  output logic                     id_bypass_a,
  output logic                     id_bypass_b,
  output logic [CNT_W-1:0]         stall_count,
  output logic [CNT_W-1:0]         flush_count
);

  localparam int SEL_W = $clog2(DEPTH);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] dest;
    logic              regwrite;
    logic              memread;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic              uses_rs;
    logic              uses_rt;
  } entry_t;

  entry_t sb_q [DEPTH];
  entry_t sb_d [DEPTH];
  entry_t id_entry;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic             load_use;
  logic             stall_int;
  logic             flush_sb;
  logic [SEL_W-1:0] fwd_a, fwd_b;

  // Register 0 is hardwired, so it can never be the source of a hazard.
  function automatic logic produces(entry_t e, logic [ADDR_W-1:0] src, logic used);
    return e.valid && e.regwrite && (e.dest != '0) && (e.dest == src) && used;
  endfunction

  always_comb begin
    id_entry          = '0;
    id_entry.valid    = id_valid;
    id_entry.dest     = id_dest;
    id_entry.regwrite = id_regwrite;
    id_entry.memread  = id_memread;
    id_entry.rs       = id_rs;
    id_entry.rt       = id_rt;
    id_entry.uses_rs  = id_uses_rs;
    id_entry.uses_rt  = id_uses_rt;
  end

  always_comb begin
    load_use  = id_valid && sb_q[0].memread &&
                (produces(sb_q[0], id_rs, id_uses_rs) || produces(sb_q[0], id_rt, id_uses_rt));
    stall_int = load_use && !redirect;
    flush_sb  = redirect && !redirect_from_id;
  end

  // Scan oldest to youngest so the youngest matching producer is left in the select.
  // A load one stage ahead cannot have its data yet; the stall keeps that case away.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int k = int'(DEPTH) - 1; k >= 1; k--) begin
      if (!sb_q[k].memread || k >= 2) begin
        if (produces(sb_q[k], sb_q[0].rs, sb_q[0].uses_rs)) fwd_a = SEL_W'(k);
        if (produces(sb_q[k], sb_q[0].rt, sb_q[0].uses_rt)) fwd_b = SEL_W'(k);
      end
    end
    if (!sb_q[0].valid) begin
      fwd_a = '0;
      fwd_b = '0;
    end
  end

  // The scoreboard always shifts; a redirect also kills everything younger than the branch.
  always_comb begin
    if (id_valid && !stall_int && !flush_sb) begin
      sb_d[0] = id_entry;
    end else begin
      sb_d[0] = '0;
    end
    for (int k = 1; k < int'(DEPTH); k++) begin
      sb_d[k] = sb_q[k-1];
      if (flush_sb && k <= int'(REDIRECT_STAGE)) begin
        sb_d[k] = '0;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_int && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (redirect && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        sb_q[k] <= '0;
      end
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        sb_q[k] <= sb_d[k];
      end
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Every output is forced low while reset is asserted.
  assign stall       = rst && stall_int;
  assign flush_if_id = rst && redirect;
  assign ex_bubble   = rst && (stall_int || flush_sb);
  assign fwd_a_sel   = rst ? fwd_a : '0;
  assign fwd_b_sel   = rst ? fwd_b : '0;
  assign id_bypass_a = rst && produces(sb_q[DEPTH-1], id_rs, id_uses_rs);
  assign id_bypass_b = rst && produces(sb_q[DEPTH-1], id_rt, id_uses_rt);
  assign stall_count = rst ? stall_cnt_q : '0;
  assign flush_count = rst ? flush_cnt_q : '0;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench for pipeline_hazard_unit: expected outputs are queued per step and
// compared against the DUT mid-cycle.
module tb_pipeline_hazard_unit;

  localparam int unsigned AW = 5;
  localparam int unsigned DP = 3;
  localparam int unsigned RS = 2;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          id_valid;
  logic [AW-1:0] id_rs, id_rt, id_dest;
  logic          id_uses_rs, id_uses_rt, id_regwrite, id_memread;
  logic          redirect, redirect_from_id;
  logic          stall, flush_if_id, ex_bubble;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          id_bypass_a, id_bypass_b;
  logic [CW-1:0] stall_count, flush_count;

  pipeline_hazard_unit #(
    .ADDR_W(AW), .DEPTH(DP), .REDIRECT_STAGE(RS), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .redirect(redirect),
    .redirect_from_id(redirect_from_id), .stall(stall), .flush_if_id(flush_if_id),
    .ex_bubble(ex_bubble), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .id_bypass_a(id_bypass_a), .id_bypass_b(id_bypass_b),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] d;
    logic       rw;
    logic       mr;
  } inst_t;

  typedef struct packed {
    logic       stall;
    logic       flush;
    logic       bub;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       ba;
    logic       bb;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;

  exp_t        exp_q[$];
  string       tag_q[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned sc_m     = 0;
  int unsigned fc_m     = 0;

  function automatic inst_t ins(int rs, int rt, int urs, int urt, int d, int rw, int mr);
    inst_t i;
    i.v   = 1'b1;
    i.rs  = 5'(rs);
    i.rt  = 5'(rt);
    i.urs = 1'(urs);
    i.urt = 1'(urt);
    i.d   = 5'(d);
    i.rw  = 1'(rw);
    i.mr  = 1'(mr);
    return i;
  endfunction

  function automatic inst_t nop();
    return '0;
  endfunction

  function automatic exp_t ex(int s, int f, int b, int fa, int fb, int ba, int bb);
    exp_t e;
    e       = '0;
    e.stall = 1'(s);
    e.flush = 1'(f);
    e.bub   = 1'(b);
    e.fa    = 2'(fa);
    e.fb    = 2'(fb);
    e.ba    = 1'(ba);
    e.bb    = 1'(bb);
    return e;
  endfunction

  task automatic check(string tag, string field, logic [15:0] obs, logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, expv);
    end
  endtask

  task automatic step(string tag, inst_t i, logic redir, logic rfi, logic rst_v, exp_t e);
    exp_t  full;
    string t;
    rst              = rst_v;
    id_valid         = i.v;
    id_rs            = i.rs;
    id_rt            = i.rt;
    id_uses_rs       = i.urs;
    id_uses_rt       = i.urt;
    id_dest          = i.d;
    id_regwrite      = i.rw;
    id_memread       = i.mr;
    redirect         = redir;
    redirect_from_id = rfi;
    full    = e;
    full.sc = 4'(sc_m);
    full.fc = 4'(fc_m);
    if (!rst_v) full = '0;
    exp_q.push_back(full);
    tag_q.push_back(tag);
    @(negedge clk);
    full = exp_q.pop_front();
    t    = tag_q.pop_front();
    check(t, "stall",       16'(stall),       16'(full.stall));
    check(t, "flush_if_id", 16'(flush_if_id), 16'(full.flush));
    check(t, "ex_bubble",   16'(ex_bubble),   16'(full.bub));
    check(t, "fwd_a_sel",   16'(fwd_a_sel),   16'(full.fa));
    check(t, "fwd_b_sel",   16'(fwd_b_sel),   16'(full.fb));
    check(t, "id_bypass_a", 16'(id_bypass_a), 16'(full.ba));
    check(t, "id_bypass_b", 16'(id_bypass_b), 16'(full.bb));
    check(t, "stall_count", 16'(stall_count), 16'(full.sc));
    check(t, "flush_count", 16'(flush_count), 16'(full.fc));
    if (!rst_v) begin
      sc_m = 0;
      fc_m = 0;
    end else begin
      if (full.stall && sc_m < 15) sc_m++;
      if (redir && fc_m < 15) fc_m++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (3) step("drain", nop(), 1'b0, 1'b0, 1'b1, ex(0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    exp_t z;
    z                = ex(0, 0, 0, 0, 0, 0, 0);
    rst              = 1'b0;
    id_valid         = 1'b0;
    id_rs            = '0;
    id_rt            = '0;
    id_dest          = '0;
    id_uses_rs       = 1'b0;
    id_uses_rt       = 1'b0;
    id_regwrite      = 1'b0;
    id_memread       = 1'b0;
    redirect         = 1'b0;
    redirect_from_id = 1'b0;
    @(posedge clk);
    #1;

    // Reset holds outputs low regardless of inputs
    step("rst0", ins(8, 8, 1, 1, 9, 1, 1), 1'b1, 1'b0, 1'b0, z);
    step("rst1", ins(8, 8, 1, 1, 9, 1, 1), 1'b1, 1'b1, 1'b0, z);
    step("post0", nop(), 1'b0, 1'b0, 1'b1, z);

    // add $3 ; sub $4,$3,$5
    step("t1_add", ins(1, 2, 1, 1, 3, 1, 0), 1'b0, 1'b0, 1'b1, z);
    step("t1_sub", ins(3, 5, 1, 1, 4, 1, 0), 1'b0, 1'b0, 1'b1, z);
    step("t1_fwd", nop(), 1'b0, 1'b0, 1'b1, ex(0, 0, 0, 1, 0, 0, 0));
    drain();

    // add $3 ; nop ; or $6,$3,$3
    step("t2_add", ins(1, 2, 1, 1, 3, 1, 0), 1'b0, 1'b0, 1'b1, z);
    step("t2_nop", nop(), 1'b0, 1'b0, 1'b1, z);
    step("t2_or", ins(3, 3, 1, 1, 6, 1, 0), 1'b0, 1'b0, 1'b1, z);
    step("t2_fwd", nop(), 1'b0, 1'b0, 1'b1, ex(0, 0, 0, 2, 2, 0, 0));
    drain();

    // add $3 ; nop ; nop ; and $7,$3,$0
    step("t3_add", ins(1, 2, 1, 1, 3, 1, 0), 1'b0, 1'b0, 1'b1, z);
    step("t3_nop1", nop(), 1'b0, 1'b0, 1'b1, z);
    step("t3_nop2", nop(), 1'b0, 1'b0, 1'b1, z);
    step("t3_byp", ins(3, 0, 1, 1, 7, 1, 0), 1'b0, 1'b0, 1'b1, ex(0, 0, 0, 0, 0, 1, 0));
    step("t3_and_ex", nop(), 1'b0, 1'b0, 1'b1, z);
    drain();

    // lw $8,0($0) ; add $9,$8,$8
    step("t4_lw", ins(0, 0, 1, 0, 8, 1, 1), 1'b0, 1'b0, 1'b1, z);
    step("t4_stall", ins(8, 8, 1, 1, 9, 1, 0), 1'b0, 1'b0, 1'b1, ex(1, 0, 1, 0, 0, 0, 0));
    step("t4_held", ins(8, 8, 1, 1, 9, 1, 0), 1'b0, 1'b0, 1'b1, z);
    step("t4_fwd", nop(), 1'b0, 1'b0, 1'b1, ex(0, 0, 0, 2, 2, 0, 0));
    drain();

    // Taken branch at index 2 kills the two younger producers
    step("t5_beq", ins(1, 2, 1, 1, 0, 0, 0), 1'b0, 1'b0, 1'b1, z);
    step("t5_add10", ins(1, 2, 1, 1, 10, 1, 0), 1'b0, 1'b0, 1'b1, z);
    step("t5_add11", ins(1, 2, 1, 1, 11, 1, 0), 1'b0, 1'b0, 1'b1, z);
    step("t5_redir", ins(10, 11, 1, 1, 13, 1, 0), 1'b1, 1'b0, 1'b1, ex(0, 1, 1, 0, 0, 0, 0));
    step("t5_after", ins(10, 11, 1, 1, 13, 1, 0), 1'b0, 1'b0, 1'b1, z);
    step("t5_after2", nop(), 1'b0, 1'b0, 1'b1, z);
    drain();

    // Same, with a load-use pending in the redirect cycle
    step("t5b_beq", ins(1, 2, 1, 1, 0, 0, 0), 1'b0, 1'b0, 1'b1, z);
    step("t5b_add", ins(1, 2, 1, 1, 10, 1, 0), 1'b0, 1'b0, 1'b1, z);
    step("t5b_lw", ins(0, 0, 1, 0, 12, 1, 1), 1'b0, 1'b0, 1'b1, z);
    step("t5b_redir", ins(12, 12, 1, 1, 13, 1, 0), 1'b1, 1'b0, 1'b1, ex(0, 1, 1, 0, 0, 0, 0));
    step("t5b_after", ins(12, 12, 1, 1, 13, 1, 0), 1'b0, 1'b0, 1'b1, z);
    step("t5b_after2", nop(), 1'b0, 1'b0, 1'b1, z);
    drain();

    // Jump resolved in ID: only IF/ID is flushed, the jump itself proceeds
    step("t6_add16", ins(1, 2, 1, 1, 16, 1, 0), 1'b0, 1'b0, 1'b1, z);
    step("t6_jal", ins(0, 0, 0, 0, 15, 1, 0), 1'b1, 1'b1, 1'b1, ex(0, 1, 0, 0, 0, 0, 0));
    step("t6_rd", ins(15, 16, 1, 1, 17, 1, 0), 1'b0, 1'b0, 1'b1, z);
    step("t6_fwd", nop(), 1'b0, 1'b0, 1'b1, ex(0, 0, 0, 1, 2, 0, 0));
    drain();

    // Register 0 never stalls, forwards or bypasses
    step("t7_lw0", ins(0, 0, 1, 0, 0, 1, 1), 1'b0, 1'b0, 1'b1, z);
    step("t7_rd0", ins(0, 0, 1, 1, 18, 1, 0), 1'b0, 1'b0, 1'b1, z);
    step("t7_add0", ins(1, 2, 1, 1, 0, 1, 0), 1'b0, 1'b0, 1'b1, z);
    step("t7_rd0b", ins(0, 0, 1, 1, 19, 1, 0), 1'b0, 1'b0, 1'b1, z);
    step("t7_fwd0", nop(), 1'b0, 1'b0, 1'b1, z);
    drain();

    // Two producers of $5: youngest wins; uses_rt=0 suppresses B
    step("t8_p1", ins(1, 2, 1, 1, 5, 1, 0), 1'b0, 1'b0, 1'b1, z);
    step("t8_p2", ins(3, 4, 1, 1, 5, 1, 0), 1'b0, 1'b0, 1'b1, z);
    step("t8_rd", ins(5, 5, 1, 0, 20, 1, 0), 1'b0, 1'b0, 1'b1, z);
    step("t8_fwd", nop(), 1'b0, 1'b0, 1'b1, ex(0, 0, 0, 1, 0, 0, 0));
    step("t8_bypb", ins(0, 5, 0, 1, 21, 1, 0), 1'b0, 1'b0, 1'b1, ex(0, 0, 0, 0, 0, 0, 1));
    drain();

    // 19 load-use stalls saturate the 4-bit stall counter at 15
    for (int i = 0; i < 19; i++) begin
      step("t9_lw", ins(1, 0, 1, 0, 8, 1, 1), 1'b0, 1'b0, 1'b1, z);
      step("t9_stall", ins(8, 0, 1, 0, 9, 1, 0), 1'b0, 1'b0, 1'b1,
           ex(1, 0, 1, 0, 0, int'(i > 0), 0));
    end

    // Reset during a stall and redirect clears everything at that edge
    step("t10_lw", ins(1, 0, 1, 0, 8, 1, 1), 1'b0, 1'b0, 1'b1, z);
    step("t10_rst", ins(8, 0, 1, 0, 9, 1, 0), 1'b1, 1'b0, 1'b0, z);
    step("t10_post", ins(8, 0, 1, 0, 9, 1, 0), 1'b0, 1'b0, 1'b1, z);
    step("t10_post2", nop(), 1'b0, 1'b0, 1'b1, z);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
